// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction fetch PC unit: state encoding and default addresses.
package fetch_pc_unit_pkg;

  localparam int unsigned InstrW = 32;

  localparam logic [31:0] DefResetPc   = 32'h0000_0000;
  localparam logic [31:0] DefExcVector = 32'h0000_0180;

  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StResp  = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next fetch address select: exception > redirect > sequential pc+4 > hold.
// The exception path exists only when FETCH_EXC_EN is defined.
module fetch_next_pc
  import fetch_pc_unit_pkg::*;
(
`ifdef FETCH_EXC_EN
  input  logic [31:0] exc_pc,
  input  logic        exc_valid,
`endif
  input  logic [31:0] pc,
  input  logic        advance,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc,
  output logic        redirect
);

  logic [31:0] seq_pc;
  logic        unused_redirect_lsbs;

  assign seq_pc               = pc + 32'd4;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    next_pc  = pc;
    redirect = 1'b0;
`ifdef FETCH_EXC_EN
    if (exc_valid) begin
      next_pc  = {exc_pc[31:2], 2'b00};
      redirect = 1'b1;
    end else
`endif
    if (redirect_valid) begin
      next_pc  = {redirect_pc[31:2], 2'b00};
      redirect = 1'b1;
    end else if (advance) begin
      next_pc = seq_pc;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch PC unit: one outstanding imem request, single-entry output slot to decode.
// Optional exception redirect enabled by defining FETCH_EXC_EN.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DefResetPc,
  parameter logic [31:0] EXC_VECTOR = DefExcVector
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
`ifdef FETCH_EXC_EN
  input  logic              exc_valid,
`endif
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [InstrW-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_pc,
  output logic [InstrW-1:0] if_instr
);

  fetch_state_e state_q;
  logic [31:0]  pc_q, pc_d;
  logic         redirect;
  logic         advance;
  logic         slot_free;

  assign slot_free = !if_valid || if_ready;
  assign advance   = (state_q == StResp) && imem_rvalid;
  // rst_n gates the request so nothing is issued while reset is held.
  assign imem_req  = rst_n && (state_q == StReq) && slot_free && !redirect;
  assign imem_addr = imem_req ? pc_q : 32'h0;

  fetch_next_pc u_next_pc (
`ifdef FETCH_EXC_EN
    .exc_pc         (EXC_VECTOR),
    .exc_valid      (exc_valid),
`endif
    .pc             (pc_q),
    .advance        (advance),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_pc        (pc_d),
    .redirect       (redirect)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StReq;
      pc_q     <= {RESET_PC[31:2], 2'b00};
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_instr <= '0;
    end else begin
      pc_q <= pc_d;
      if (if_valid && if_ready) begin
        if_valid <= 1'b0;
      end
      case (state_q)
        StReq: begin
          if (redirect) begin
            if_valid <= 1'b0;
          end else if (imem_req && imem_gnt) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          if (redirect) begin
            // Squash: a response already here is dropped, otherwise drain it later.
            if_valid <= 1'b0;
            state_q  <= imem_rvalid ? StReq : StDrain;
          end else if (imem_rvalid) begin
            if_valid <= 1'b1;
            if_pc    <= pc_q;
            if_instr <= imem_rdata;
            state_q  <= StReq;
          end
        end
        StDrain: begin
          if (imem_rvalid) begin
            state_q <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase
    end
  end

endmodule
